// File: rtl/sd_spi_byte_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sd_spi_pkg
// Brief   : Shared constants for the SD SPI byte master (FSM codes, idle line).
// Revision: 1.0 - initial release
// ============================================================================
package sd_spi_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOW  = 2'd1;
    localparam logic [1:0] c_ST_HIGH = 2'd2;

    localparam logic       SPI_IDLE_MOSI = 1'b1;
    localparam logic [7:0] DUMMY_BYTE    = 8'hFF;

    // Shift register contents that hold MOSI at its idle level
    localparam logic [7:0] c_IDLE_SR = {8{SPI_IDLE_MOSI}};

endpackage
`default_nettype wire

// File: rtl/sd_spi_byte_master_if.sv
`default_nettype none
// ============================================================================
// Module  : sd_spi_byte_master_if
// Brief   : Host-side byte interface of the SD SPI byte master.
// Revision: 1.0 - initial release
// ============================================================================
interface sd_spi_byte_master_if;

    logic [7:0] tx_data;
    logic       tx_wr;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_full;
    logic       tx_ovf;

    modport master (
        output tx_data, tx_wr, rx_rd,
        input  rx_data, rx_valid, busy, tx_full, tx_ovf
    );

    modport slave (
        input  tx_data, tx_wr, rx_rd,
        output rx_data, rx_valid, busy, tx_full, tx_ovf
    );

endinterface
`default_nettype wire

// File: rtl/sd_spi_byte_master_clkgen.sv
`default_nettype none
// ============================================================================
// Module  : sd_spi_clkgen
// Brief   : SCK half-period divider; ticks every CLK_DIV cycles while running.
// Revision: 1.0 - initial release
// ============================================================================
module sd_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic nRESET,
    input  wire logic i_en,
    input  wire logic i_clr,
    output logic      o_tick
);

    localparam logic [7:0] c_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_div;
    logic       w_run;

    assign w_run  = i_en & ~i_clr;
    assign o_tick = w_run & (r_div == c_LAST);

    // Restart on every tick so each phase change begins a fresh half-period
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_div <= 8'd0;
        end else if (!w_run || o_tick) begin
            r_div <= 8'd0;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module  : sd_spi_byte_master
// Brief   : Mode-0 MSB-first SPI byte master with one-entry TX holding register.
// Revision: 1.0 - initial release
// ============================================================================
module sd_spi_byte_master
    import sd_spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int AUTO_READ = 1
) (
    input  wire logic            clk,
    input  wire logic            nRESET,
    input  wire logic            SD_READY,
    sd_spi_byte_master_if.slave  bus,
    output logic                 MOSI,
    output logic                 SCK,
    input  wire logic            MISO
);

    localparam logic c_AUTO = (AUTO_READ != 0);

    logic [1:0] r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bc;
    logic       r_cap;
    logic       r_sck;
    logic [7:0] r_hold;
    logic       r_tx_full;
    logic       r_tx_ovf;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    logic       w_tick;
    logic       w_idle;
    logic       w_direct;
    logic       w_start;
    logic [7:0] w_start_byte;
    logic [7:0] w_shifted;
    logic       w_byte_done;

    sd_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk    (clk),
        .nRESET (nRESET),
        .i_en   (~w_idle),
        .i_clr  (~SD_READY),
        .o_tick (w_tick)
    );

    assign w_idle       = (r_state == c_ST_IDLE);
    assign w_direct     = w_idle & ~r_tx_full & bus.tx_wr;
    assign w_start      = w_idle & (r_tx_full | bus.tx_wr | (c_AUTO & bus.rx_rd));
    assign w_start_byte = r_tx_full ? r_hold : (bus.tx_wr ? bus.tx_data : DUMMY_BYTE);
    assign w_shifted    = {r_sr[6:0], r_cap};
    assign w_byte_done  = (r_state == c_ST_HIGH) & w_tick & (r_bc == 3'd0);

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state    <= c_ST_IDLE;
            r_sr       <= c_IDLE_SR;
            r_bc       <= 3'd0;
            r_cap      <= 1'b0;
            r_sck      <= 1'b0;
            r_hold     <= 8'd0;
            r_tx_full  <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_rx_data  <= 8'hFF;
            r_rx_valid <= 1'b0;
        end else if (!SD_READY) begin
            // Link lost: drop the partial byte and any queued byte, keep RX state
            r_state   <= c_ST_IDLE;
            r_sck     <= 1'b0;
            r_sr      <= c_IDLE_SR;
            r_tx_full <= 1'b0;
        end else begin
            if (w_byte_done) begin
                r_rx_data  <= w_shifted;
                r_rx_valid <= 1'b1;
            end else if (bus.rx_rd) begin
                r_rx_valid <= 1'b0;
            end

            if (bus.tx_wr && !w_direct) begin
                if (!r_tx_full) begin
                    r_hold    <= bus.tx_data;
                    r_tx_full <= 1'b1;
                end else begin
                    r_tx_ovf  <= 1'b1;
                end
            end
            if (r_tx_full && (w_start || w_byte_done)) begin
                r_tx_full <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_state <= c_ST_LOW;
                        r_sr    <= w_start_byte;
                        r_bc    <= 3'd7;
                    end
                end
                c_ST_LOW: begin
                    if (w_tick) begin
                        r_state <= c_ST_HIGH;
                        r_sck   <= 1'b1;
                        r_cap   <= MISO;
                    end
                end
                c_ST_HIGH: begin
                    if (w_tick) begin
                        r_sck <= 1'b0;
                        if (r_bc != 3'd0) begin
                            r_state <= c_ST_LOW;
                            r_bc    <= r_bc - 3'd1;
                            r_sr    <= w_shifted;
                        end else if (r_tx_full) begin
                            // Chain straight into the queued byte with no idle cycle
                            r_state <= c_ST_LOW;
                            r_bc    <= 3'd7;
                            r_sr    <= r_hold;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_sr    <= c_IDLE_SR;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_sck   <= 1'b0;
                    r_sr    <= c_IDLE_SR;
                end
            endcase
        end
    end

    // MOSI is the shift-register MSB, which is all-ones whenever idle
    assign MOSI         = r_sr[7];
    assign SCK          = r_sck;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_full  = r_tx_full;
    assign bus.tx_ovf   = r_tx_ovf;
    assign bus.busy     = ~w_idle | r_tx_full;

endmodule
`default_nettype wire
